// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target that turns host frames into single-cycle register-file strobes.
// Latency: pin edges seen SYNC_STAGES+1 clocks late; write_en at R+1, read_en at R+1 (cmd) / R+2 (data), miso by R+4.
// Backpressure: none; the SPI host paces the frame and the register file accepts every strobe.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [5:0] address,
  output logic       write_en,
  output logic [7:0] wr_data,
  output logic       read_en,
  input  logic [7:0] rd_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Synchroniser chains and one history flop per pin for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   mosi_d;

  logic sclk_s;
  logic cs_s;
  logic rise;
  logic fall;
  logic cs_assert;
  logic cs_deassert;

  // Frame datapath state.
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nxt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       rw;
  logic       active_rise;
  logic       byte_done;
  logic       addr_inc_pend;
  logic       prefetch_pend;
  logic       capture_pend;
  logic       skip_fall;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign rise        = sclk_s & ~sclk_d;
  assign fall        = ~sclk_s & sclk_d;
  assign cs_assert   = ~cs_s & cs_d;
  assign cs_deassert = cs_s & ~cs_d;

  // Rising edges only count once a frame is open; the 8th one closes a byte.
  assign active_rise = rise && (state != IDLE);
  assign byte_done   = active_rise && (bit_cnt == 3'd7);
  assign bit_cnt_nxt = active_rise ? (bit_cnt + 3'd1) : bit_cnt;

  // Bring the asynchronous SPI pins into the clock domain and keep one cycle of history.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      mosi_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Frame state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing; chip-select release always wins after any same-cycle rise is handled.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_assert) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = DATA;
      DATA:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
    if (cs_deassert) state_nxt = IDLE;
  end

  // Pin-facing outputs: miso only carries data during the data phase of a read.
  always_comb begin
    miso    = 1'b0;
    miso_oe = (state != IDLE);
    if ((state == DATA) && rw) miso = tx_shift[7];
  end

  // Shift-in, strobe generation, address stepping and read prefetch/shift-out.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      rw            <= 1'b0;
      address       <= '0;
      wr_data       <= '0;
      write_en      <= 1'b0;
      read_en       <= 1'b0;
      frame_err     <= 1'b0;
      addr_inc_pend <= 1'b0;
      prefetch_pend <= 1'b0;
      capture_pend  <= 1'b0;
      skip_fall     <= 1'b0;
    end else begin
      write_en      <= 1'b0;
      read_en       <= prefetch_pend;
      prefetch_pend <= 1'b0;
      capture_pend  <= read_en;
      addr_inc_pend <= 1'b0;
      // A rise landing with the release is counted first, so a completed byte is not an error.
      frame_err     <= cs_deassert && (state != IDLE) && (bit_cnt_nxt != 3'd0);

      // Writes step the address one cycle after the strobe so wr_data pairs with the old address.
      if (addr_inc_pend) address <= address + 6'd1;

      if (cs_assert && (state == IDLE)) begin
        bit_cnt   <= '0;
        skip_fall <= 1'b0;
      end

      if (active_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_d};
        bit_cnt  <= bit_cnt_nxt;
        if (byte_done) begin
          // The next byte's MSB is already on miso, so the following fall must not shift.
          skip_fall <= 1'b1;
          if (state == CMD) begin
            rw      <= rx_shift[6];
            address <= {rx_shift[4:0], mosi_d};
            read_en <= rx_shift[6];
          end else if (rw) begin
            address       <= address + 6'd1;
            prefetch_pend <= 1'b1;
          end else begin
            write_en      <= 1'b1;
            wr_data       <= {rx_shift, mosi_d};
            addr_inc_pend <= 1'b1;
          end
        end
      end

      if (fall && (state == DATA) && skip_fall) skip_fall <= 1'b0;

      // rd_data is valid the cycle after read_en; otherwise shift out on data-phase falls.
      if (capture_pend) begin
        tx_shift <= rd_data;
      end else if (fall && (state == DATA) && !skip_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule
